state_replayer: RTL and testbench
=================================

// Module: state_replayer
// PURPOSE
//  Walks the 512-byte state snapshot captured by the bus sniffer and replays it as an ordered
//  stream of CPU register commands (PPU OAM, PPU regs, APU regs) over a valid/ready handshake.
//  Sits between the snapshot readout port and the save-state restore path, which turns each
//  command into a CPU bus cycle. It is the write-back direction of state capture.
// PARAMETERS
//  OAM_BASE    9'h000  snapshot address of OAM byte 0 (256 bytes)
//  APU_BASE    9'h100  snapshot address of $4000 (24 bytes)
//  PPU_BASE    9'h118  snapshot address of $2000, then $2005 first, $2005 second, $2001
//  GAP_CYCLES  0       idle cycles inserted after each accepted command (0..255)
// PORTS
//  clk        in   1   single clock for the block
//  reset_n    in   1   synchronous reset, active low
//  start      in   1   one-cycle pulse; starts a replay when idle
//  abort      in   1   one-cycle pulse; stops a replay in progress
//  busy       out  1   high from the cycle after an accepted start until done or abort
//  done       out  1   one-cycle pulse after the last command is accepted
//  rd_addr    out  9   snapshot read address
//  rd_data    in   8   snapshot data, valid exactly 1 clk after rd_addr
//  cmd_valid  out  1   command available
//  cmd_ready  in   1   consumer accepts the command when cmd_valid && cmd_ready
//  cmd_addr   out  16  CPU address
//  cmd_data   out  8   write data; 8'h00 for reads
//  cmd_rw     out  1   1 = dummy read (toggle reset), 0 = write
// BEHAVIOUR
//  - Reset (reset_n low at posedge): busy=0, done=0, cmd_valid=0, cmd_addr=0, cmd_data=0,
//    cmd_rw=0, rd_addr=0; FSM goes to IDLE. A reset in mid-replay drops cmd_valid on the same edge.
//  - FSM states: IDLE -> FETCH (drive rd_addr) -> LATCH (capture rd_data into cmd_data)
//    -> OFFER (cmd_valid=1 until handshake) -> GAP (GAP_CYCLES>0 only) -> next FETCH or OFFER.
//    Commands with constant data skip FETCH/LATCH. When the last command is accepted: done=1
//    for one cycle, then IDLE.
//  - Sequence index 0..N-1. 9-bit counter; OAM offset = index-2, an 8-bit value.
//    0: rw=1 $2002        1: $2003<=00        2..257: $2004<=snap[OAM_BASE+0..255]
//    258: $2000<=snap[PPU_BASE+0]   259: $2001<=snap[PPU_BASE+3]   260: rw=1 $2002
//    261: $2005<=snap[PPU_BASE+1]   262: $2005<=snap[PPU_BASE+2]
//    263..282: $4000..$4013<=snap[APU_BASE+0..19]
//    283: $4015<=snap[APU_BASE+21]  284: $4017<=snap[APU_BASE+23]
//    $4014 (OAM DMA) and $4016 (pad strobe) are never emitted.
//  - Handshake: while cmd_valid && !cmd_ready, cmd_addr, cmd_data and cmd_rw hold stable.
//    cmd_valid never drops without a handshake, except on abort or reset.
//  - Minimum spacing with cmd_ready tied high and GAP_CYCLES=0: 3 clk per fetched command,
//    1 clk per constant command.
//  - start while busy: ignored. start and abort in the same cycle while idle: start wins.
//  - abort while busy: on the next edge cmd_valid=0, busy=0, go to IDLE, no done pulse.
//    A handshake in the abort cycle itself still counts as accepted.
//  - rd_addr holds its last value outside FETCH. The snapshot is not modified by this block.
// CONFIGURATION
//  STATE_REPLAYER_APU_EN defined: full sequence as above, N=285.
//  Undefined: the sequence ends after index 262 (N=263), and done pulses after the second
//  $2005 write. No APU logic is generated.
// TESTING
//  1. Snapshot byte i = i[7:0]; start, ready=1 -> 285 cmds in order; $2004 data 00..FF;
//     $2000=18, $2001=1B, $2005=19 then 1A; done one clk after the $4017 handshake.
//  2. Random cmd_ready (50%) -> identical command list to test 1; outputs stable while stalled.
//  3. Abort at the 100th $2004 offer -> next clk cmd_valid=0, busy=0, no done; restart replays
//     from index 0.
//  4. reset_n=0 while cmd_valid=1 -> all outputs 0 at that edge; start after release works.
//  5. start pulsed while busy -> ignored; exactly one done pulse, 285 cmds.
//  6. APU_EN undefined and GAP_CYCLES=2 -> 263 cmds, >=2 idle clk between offers, no $4xxx.

Source files
------------

// File: rtl/state_replayer.sv
// Replays the 512-byte sniffer snapshot as an ordered stream of CPU register commands.
// Optional APU register replay is built only when STATE_REPLAYER_APU_EN is defined.
module state_replayer #(
    parameter logic [8:0]  OAM_BASE   = 9'h000,
`ifdef STATE_REPLAYER_APU_EN
    parameter logic [8:0]  APU_BASE   = 9'h100,
`endif
    parameter logic [8:0]  PPU_BASE   = 9'h118,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [8:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        cmd_rw
);

`ifdef STATE_REPLAYER_APU_EN
    localparam logic [8:0] LAST_IDX = 9'd284;
`else
    localparam logic [8:0] LAST_IDX = 9'd262;
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_OFFER, S_GAP} state_t;

    typedef struct packed {
        logic        fetch;
        logic        rw;
        logic [15:0] addr;
        logic [8:0]  saddr;
    } step_t;

    // Maps a sequence index to its CPU address and, for fetched commands, the snapshot byte.
    function automatic step_t decode(input logic [8:0] idx);
        step_t s;
        s = '0;
        if (idx == 9'd0 || idx == 9'd260) begin
            s.rw   = 1'b1;
            s.addr = 16'h2002;
        end else if (idx == 9'd1) begin
            s.addr = 16'h2003;
        end else if (idx <= 9'd257) begin
            s.fetch = 1'b1;
            s.addr  = 16'h2004;
            s.saddr = OAM_BASE + {1'b0, 8'(idx - 9'd2)};
        end else if (idx == 9'd258) begin
            s.fetch = 1'b1;
            s.addr  = 16'h2000;
            s.saddr = PPU_BASE;
        end else if (idx == 9'd259) begin
            s.fetch = 1'b1;
            s.addr  = 16'h2001;
            s.saddr = PPU_BASE + 9'd3;
        end else if (idx == 9'd261) begin
            s.fetch = 1'b1;
            s.addr  = 16'h2005;
            s.saddr = PPU_BASE + 9'd1;
        end else if (idx == 9'd262) begin
            s.fetch = 1'b1;
            s.addr  = 16'h2005;
            s.saddr = PPU_BASE + 9'd2;
        end
`ifdef STATE_REPLAYER_APU_EN
        else if (idx <= 9'd282) begin
            s.fetch = 1'b1;
            s.addr  = 16'h4000 + {11'd0, 5'(idx - 9'd263)};
            s.saddr = APU_BASE + {4'd0, 5'(idx - 9'd263)};
        end else if (idx == 9'd283) begin
            s.fetch = 1'b1;
            s.addr  = 16'h4015;
            s.saddr = APU_BASE + 9'd21;
        end else if (idx == 9'd284) begin
            s.fetch = 1'b1;
            s.addr  = 16'h4017;
            s.saddr = APU_BASE + 9'd23;
        end
`endif
        return s;
    endfunction

    state_t     r_state;
    logic [8:0] r_idx;
    logic [7:0] r_gap;

    logic [8:0] w_load_idx;
    step_t      w_ld;
    logic       w_load;

    assign w_load_idx = (r_state == S_IDLE) ? 9'd0 : r_idx + 9'd1;
    assign w_ld       = decode(w_load_idx);
    assign w_load     = (r_state == S_IDLE && start)
                     || (r_state == S_OFFER && cmd_ready && r_idx != LAST_IDX && GAP_CYCLES == 0)
                     || (r_state == S_GAP && r_gap == 8'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_gap     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_rw    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE:  ;
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    cmd_data  <= rd_data;
                    cmd_valid <= 1'b1;
                    r_state   <= S_OFFER;
                end
                S_OFFER: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (GAP_CYCLES != 0) begin
                            r_gap   <= 8'(GAP_CYCLES - 1);
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP:   if (r_gap != 8'd0) r_gap <= r_gap - 8'd1;
                default: r_state <= S_IDLE;
            endcase

            // Address/rw are loaded while cmd_valid is low, so a fetched command only adds data later.
            if (w_load) begin
                r_idx    <= w_load_idx;
                busy     <= 1'b1;
                cmd_addr <= w_ld.addr;
                cmd_rw   <= w_ld.rw;
                if (w_ld.fetch) begin
                    rd_addr <= w_ld.saddr;
                    r_state <= S_FETCH;
                end else begin
                    cmd_data  <= 8'h00;
                    cmd_valid <= 1'b1;
                    r_state   <= S_OFFER;
                end
            end

            if (busy && abort) begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_state_replayer.sv
// Self-checking bench for state_replayer: one instance with no gap, one with GAP_CYCLES=2.
`timescale 1ns/1ps
module tb_state_replayer;
`ifdef STATE_REPLAYER_APU_EN
    localparam int N = 285;
`else
    localparam int N = 263;
`endif
    localparam int OAM_B = 'h000;
    localparam int APU_B = 'h100;
    localparam int PPU_B = 'h118;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    typedef struct {
        int   idx;
        cmd_t c;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_start, a_abort, a_busy, a_done, a_cmd_valid, a_cmd_ready, a_cmd_rw;
    logic [8:0]  a_rd_addr;
    logic [7:0]  a_rd_data, a_cmd_data;
    logic [15:0] a_cmd_addr;
    logic        b_start, b_abort, b_busy, b_done, b_cmd_valid, b_cmd_ready, b_cmd_rw;
    logic [8:0]  b_rd_addr;
    logic [7:0]  b_rd_data, b_cmd_data;
    logic [15:0] b_cmd_addr;

    logic [7:0] mem [512];
    always @(posedge clk) begin
        a_rd_data <= mem[a_rd_addr];
        b_rd_data <= mem[b_rd_addr];
    end

    state_replayer #(.GAP_CYCLES(0)) u_a (
        .clk(clk), .reset_n(rst_n), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_addr(a_cmd_addr),
        .cmd_data(a_cmd_data), .cmd_rw(a_cmd_rw)
    );

    state_replayer #(.GAP_CYCLES(2)) u_b (
        .clk(clk), .reset_n(rst_n), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_addr(b_cmd_addr),
        .cmd_data(b_cmd_data), .cmd_rw(b_cmd_rw)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    cmd_t cap_a[$], cap_b[$], exp_q[$];
    int   hs_a[$], hs_b[$];
    int   done_a = 0, done_b = 0, done_cyc_a = 0;
    vec_t vecs[$];

    always @(posedge clk) cyc++;

    // Monitor A: capture handshakes, count done pulses, check hold-while-stalled.
    logic a_stall = 1'b0, a_excuse = 1'b1;
    cmd_t a_prev;
    always @(negedge clk) begin
        cmd_t cur;
        cur = cmd_t'({a_cmd_rw, a_cmd_addr, a_cmd_data});
        if (rst_n && a_cmd_valid && a_cmd_ready) begin
            cap_a.push_back(cur);
            hs_a.push_back(cyc);
        end
        if (a_done) begin
            done_a++;
            done_cyc_a = cyc;
        end
        if (a_stall && !a_excuse) begin
            checks++;
            if (!a_cmd_valid || cur !== a_prev) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b %h required v=1 %h", a_cmd_valid, cur, a_prev);
            end
        end
        a_stall  = a_cmd_valid && !a_cmd_ready;
        a_prev   = cur;
        a_excuse = a_abort || !rst_n;
    end

    // Monitor B: capture handshakes, check idle spacing between offers.
    logic b_vprev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && b_cmd_valid && !b_vprev && hs_b.size() > 0) begin
            checks++;
            if (cyc - hs_b[$] < 3) begin
                errors++;
                $display("FAIL gap_spacing: got %0d clk since handshake required >=3", cyc - hs_b[$]);
            end
`ifndef STATE_REPLAYER_APU_EN
            checks++;
            if (b_cmd_addr[15:12] == 4'h4) begin
                errors++;
                $display("FAIL no_apu: got addr %h required no $4xxx", b_cmd_addr);
            end
`endif
        end
        if (rst_n && b_cmd_valid && b_cmd_ready) begin
            cap_b.push_back(cmd_t'({b_cmd_rw, b_cmd_addr, b_cmd_data}));
            hs_b.push_back(cyc);
        end
        if (b_done) done_b++;
        b_vprev = b_cmd_valid;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    // Reference sequence built straight from the replay order rules.
    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(cmd_t'({1'b1, 16'h2002, 8'h00}));
        exp_q.push_back(cmd_t'({1'b0, 16'h2003, 8'h00}));
        for (int k = 0; k < 256; k++) exp_q.push_back(cmd_t'({1'b0, 16'h2004, mem[OAM_B + k]}));
        exp_q.push_back(cmd_t'({1'b0, 16'h2000, mem[PPU_B]}));
        exp_q.push_back(cmd_t'({1'b0, 16'h2001, mem[PPU_B + 3]}));
        exp_q.push_back(cmd_t'({1'b1, 16'h2002, 8'h00}));
        exp_q.push_back(cmd_t'({1'b0, 16'h2005, mem[PPU_B + 1]}));
        exp_q.push_back(cmd_t'({1'b0, 16'h2005, mem[PPU_B + 2]}));
`ifdef STATE_REPLAYER_APU_EN
        for (int r = 0; r < 24; r++)
            if (r != 20 && r != 22)
                exp_q.push_back(cmd_t'({1'b0, 16'h4000 + 16'(r), mem[APU_B + r]}));
`endif
    endtask

    task automatic check_list(input string nm, input cmd_t got[$]);
        int bad;
        bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: cmd %0d got %h required %h", nm, bad, got[bad], exp_q[bad]);
        end else if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s: got %0d cmds required %0d", nm, got.size(), exp_q.size());
        end
    endtask

    // mode 0: ready high, 1: ready random, 2: ready low
    task automatic a_cycle(input int mode);
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_abort = 1'b0;
        a_cmd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic run_a(input int mode, input int extra_at);
        int n;
        cap_a.delete();
        hs_a.delete();
        done_a = 0;
        a_start = 1'b1;
        a_cycle(mode);
        chk("busy_after_start", 32'(a_busy), 32'd1);
        n = 0;
        while (done_a == 0 && n < 6000) begin
            if (n == extra_at) a_start = 1'b1;
            a_cycle(mode);
            n++;
        end
        if (done_a == 0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got no done after %0d clk required done", n);
        end
        repeat (4) a_cycle(mode);
    endtask

    function automatic int count_2004();
        int c;
        c = 0;
        foreach (cap_a[i]) if (cap_a[i].addr == 16'h2004) c++;
        return c;
    endfunction

    initial begin
        int n, bad, exp_d;
        bit found;

        rst_n = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_cmd_ready = 1'b1;
        b_start = 1'b0; b_abort = 1'b0; b_cmd_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);

        vecs.push_back('{idx: 0,   c: cmd_t'({1'b1, 16'h2002, 8'h00})});
        vecs.push_back('{idx: 1,   c: cmd_t'({1'b0, 16'h2003, 8'h00})});
        vecs.push_back('{idx: 2,   c: cmd_t'({1'b0, 16'h2004, 8'h00})});
        vecs.push_back('{idx: 101, c: cmd_t'({1'b0, 16'h2004, 8'h63})});
        vecs.push_back('{idx: 257, c: cmd_t'({1'b0, 16'h2004, 8'hFF})});
        vecs.push_back('{idx: 258, c: cmd_t'({1'b0, 16'h2000, 8'h18})});
        vecs.push_back('{idx: 259, c: cmd_t'({1'b0, 16'h2001, 8'h1B})});
        vecs.push_back('{idx: 260, c: cmd_t'({1'b1, 16'h2002, 8'h00})});
        vecs.push_back('{idx: 261, c: cmd_t'({1'b0, 16'h2005, 8'h19})});
        vecs.push_back('{idx: 262, c: cmd_t'({1'b0, 16'h2005, 8'h1A})});
`ifdef STATE_REPLAYER_APU_EN
        vecs.push_back('{idx: 263, c: cmd_t'({1'b0, 16'h4000, 8'h00})});
        vecs.push_back('{idx: 282, c: cmd_t'({1'b0, 16'h4013, 8'h13})});
        vecs.push_back('{idx: 283, c: cmd_t'({1'b0, 16'h4015, 8'h15})});
        vecs.push_back('{idx: 284, c: cmd_t'({1'b0, 16'h4017, 8'h17})});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_valid", 32'(a_cmd_valid), 32'd0);
        chk("rst_addr", 32'(a_cmd_addr), 32'd0);
        chk("rst_data", 32'(a_cmd_data), 32'd0);
        chk("rst_rw", 32'(a_cmd_rw), 32'd0);
        chk("rst_rd_addr", 32'(a_rd_addr), 32'd0);
        rst_n = 1'b1;
        a_cycle(0);

        // Full replay, ready always high, identity snapshot
        run_a(0, -1);
        build_exp();
        check_list("t1_list", cap_a);
        foreach (vecs[v]) begin
            checks++;
            if (vecs[v].idx >= cap_a.size() || cap_a[vecs[v].idx] !== vecs[v].c) begin
                errors++;
                $display("FAIL t1_vec%0d: got %h required %h", vecs[v].idx,
                         (vecs[v].idx < cap_a.size()) ? cap_a[vecs[v].idx] : cmd_t'('0), vecs[v].c);
            end
        end
        bad = -1;
        for (int i = 1; i < hs_a.size(); i++) begin
            exp_d = (i == 1 || i == 260) ? 1 : 3;
            if (hs_a[i] - hs_a[i-1] != exp_d) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad >= 0 || hs_a.size() != N) begin
            errors++;
            $display("FAIL t1_spacing: got bad step at cmd %0d (n=%0d) required min spacing, n=%0d", bad, hs_a.size(), N);
        end
        if (hs_a.size() > 0) chk("t1_done_latency", 32'(done_cyc_a), 32'(hs_a[$] + 1));
        chk("t1_done_count", 32'(done_a), 32'd1);
        chk("t1_busy_after", 32'(a_busy), 32'd0);

        // Random snapshot, random ready
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_a(1, -1);
        build_exp();
        check_list("t2_list", cap_a);
        chk("t2_done_count", 32'(done_a), 32'd1);

        // Abort at the 100th $2004 offer
        cap_a.delete();
        hs_a.delete();
        done_a = 0;
        a_start = 1'b1;
        a_cycle(0);
        n = 0;
        found = 1'b0;
        while (!found && n < 2000) begin
            if (a_cmd_valid && a_cmd_addr == 16'h2004 && count_2004() == 99) found = 1'b1;
            else begin
                a_cycle(0);
                n++;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL t3_reach: got no 100th $2004 offer required one");
        end
        a_abort = 1'b1;
        a_cycle(0);
        chk("t3_valid_off", 32'(a_cmd_valid), 32'd0);
        chk("t3_busy_off", 32'(a_busy), 32'd0);
        repeat (10) a_cycle(0);
        chk("t3_accepted", 32'(cap_a.size()), 32'd102);
        chk("t3_no_done", 32'(done_a), 32'd0);
        chk("t3_idle_valid", 32'(a_cmd_valid), 32'd0);
        run_a(0, -1);
        check_list("t3_restart", cap_a);

        // Reset while a command is offered
        a_start = 1'b1;
        a_cycle(2);
        a_cycle(2);
        chk("t4_pre_valid", 32'(a_cmd_valid), 32'd1);
        rst_n = 1'b0;
        a_cycle(2);
        chk("t4_busy", 32'(a_busy), 32'd0);
        chk("t4_valid", 32'(a_cmd_valid), 32'd0);
        chk("t4_addr", 32'(a_cmd_addr), 32'd0);
        chk("t4_data", 32'(a_cmd_data), 32'd0);
        chk("t4_rw", 32'(a_cmd_rw), 32'd0);
        chk("t4_rd_addr", 32'(a_rd_addr), 32'd0);
        chk("t4_done", 32'(a_done), 32'd0);
        rst_n = 1'b1;
        a_cycle(0);
        run_a(0, -1);
        check_list("t4_after_reset", cap_a);

        // start pulsed while busy
        run_a(0, 50);
        check_list("t5_list", cap_a);
        chk("t5_done_count", 32'(done_a), 32'd1);

        // Gap instance
        cap_b.delete();
        hs_b.delete();
        done_b = 0;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        n = 0;
        while (done_b == 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_b == 0) begin
            checks++;
            errors++;
            $display("FAIL t6_timeout: got no done after %0d clk required done", n);
        end
        repeat (4) @(posedge clk);
        #1;
        check_list("t6_list", cap_b);
        chk("t6_count", 32'(cap_b.size()), 32'(N));
        chk("t6_done_count", 32'(done_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
